ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the board seven-segment display decoder. It samples the keyboard clock and data lines in the system clock domain and deframes 11-bit PS/2 frames. Valid scan codes are buffered in a small FIFO, and the block tracks make/break state. It drives the current key code, the key-down flag and the press count that the display stage splits into nibbles, one per digit.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT, 2000, idle system-clock cycles between PS/2 falling edges after which a partial frame is discarded.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ps2_clk  input  1  raw keyboard clock, asynchronous to clk
ps2_data  input  1  raw keyboard data, asynchronous to clk
rd_en  input  1  FIFO pop request from consumer
rd_data  output  8  FIFO head scan code, valid when rd_valid=1
rd_valid  output  1  FIFO non-empty
overflow  output  1  sticky: a frame arrived while the FIFO was full
frame_err  output  1  one-cycle pulse when a frame is rejected
cur_code  output  8  most recent make code
key_down  output  1  cur_code is currently held
key_cnt  output  8  number of distinct key presses, modulo 256

Behaviour:
- Reset is synchronous. While rst=1 on a clk edge, all of the following are cleared:
  - synchronizer, bit counter, shift register, timeout counter
  - FIFO pointers and count
  - break_pending
  - rd_valid, overflow, frame_err, cur_code, key_down, key_cnt
  - rd_data reads 0.
- Reset mid-frame abandons the partial frame. The next falling edge is treated as a start bit.
- Synchronization:
  - ps2_clk passes through a 3-flop chain; ps2_data passes through a 2-flop chain.
  - A falling edge (fall) is flagged when the two oldest clock taps read 1 then 0.
  - Data is sampled on the fall cycle.
- Deframing:
  - A bit counter runs 0..10 and advances on each fall.
  - Bit 0 is the start bit (must be 0). Bits 1-8 are data, LSB first. Bit 9 is odd parity: the XOR of the 8 data bits and the parity bit must be 1. Bit 10 is the stop bit (must be 1).
  - On the fall that samples bit 10, the counter returns to 0 and the frame is checked.
  - A good frame is pushed to the FIFO and applied to the make/break logic on the next clk edge. rd_valid rises on that edge if the FIFO was empty.
  - A bad frame (start, parity or stop wrong) is not pushed and does not update state. frame_err=1 for exactly one cycle.
- Timeout:
  - While the bit counter is non-zero, a counter increments every clk and clears on each fall.
  - Reaching TIMEOUT resets the bit counter to 0 silently: no frame_err, no push.
- FIFO:
  - rd_data = mem[rd_ptr], combinational from registered state.
  - A pop happens when rd_en=1 and rd_valid=1. rd_en while empty is ignored.
  - Push when full without a same-cycle pop: the byte is dropped and overflow is set to 1 until rst.
  - Push when full with a same-cycle pop: both happen, count is unchanged, no overflow.
  - Push and pop on the same cycle when count=1: rd_valid stays 1 and rd_data shows the new byte.
- Make/break (applied to good frames only; every good byte is also pushed):
  - 0xE0 is ignored; it does not change break_pending.
  - 0xF0 sets break_pending=1.
  - Any other byte with break_pending=1: clears break_pending. If the byte equals cur_code, key_down is cleared to 0. cur_code and key_cnt are unchanged.
  - Any other byte with break_pending=0 and (key_down=0 or byte != cur_code): cur_code takes the byte, key_down is set to 1, key_cnt increments (wraps 255 to 0).
  - Any other byte with break_pending=0, key_down=1 and byte == cur_code: typematic repeat, no change.

Test Plan:
- Reset, then send frame 0x1C (parity bit 0), holding rd_en=0. Required: one cycle after the 11th fall, rd_valid=1, rd_data=0x1C, cur_code=0x1C, key_down=1, key_cnt=1.
- Send 0x1C three more times (typematic), then F0 1C. Required: key_cnt stays 1, key_down=0 after the final byte, FIFO holds 1C,1C,1C,1C,F0,1C in that order.
- Send a frame with a corrupted parity bit. Required: frame_err high for exactly 1 cycle, FIFO count and cur_code unchanged. Then send 0x32. Required: accepted normally, cur_code=0x32.
- Send 4 bits of a frame, idle TIMEOUT+5 cycles, then send a clean 0x24. Required: 0x24 received, no frame_err.
- With DEPTH=8 and rd_en=0, send 9 frames. Required: overflow=1, first 8 bytes kept in order. Then send a 10th frame with rd_en=1 on its push cycle. Required: pop and push both occur, count stays 8.
- Send 256 distinct make/break pairs alternating 0x15 and 0x1D. Required: key_cnt wraps to 0. Assert rst mid-frame. Required: all outputs 0 on the next cycle, and a following clean frame is received correctly.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// Consumer-side bundle of the PS/2 keyboard receiver: FIFO read port plus key status.
interface ps2_kbd_rx_if;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overflow;
    logic       frame_err;
    logic [7:0] cur_code;
    logic       key_down;
    logic [7:0] key_cnt;

    // Receiver side: produces codes and status, accepts pops.
    modport master (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output overflow,
        output frame_err,
        output cur_code,
        output key_down,
        output key_cnt
    );

    // Consumer side (display stage).
    modport slave (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  overflow,
        input  frame_err,
        input  cur_code,
        input  key_down,
        input  key_cnt
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, deframes 11-bit frames,
// buffers good scan codes in a FIFO and tracks make/break key state.
module ps2_kbd_rx #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_kbd_rx_if.master  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    // Synchronizers; index 2 / 1 is the oldest tap.
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;

    // Deframer state
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // FIFO state
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Status state
    logic          frame_err_q, frame_err_d;
    logic [7:0]    cur_code_q, cur_code_d;
    logic          key_down_q, key_down_d;
    logic [7:0]    key_cnt_q, key_cnt_d;
    logic          brk_q, brk_d;

    logic          fall;
    logic          bit_in;
    logic          frame_done;
    logic          frame_good;
    logic [7:0]    frame_byte;
    logic          tmo_hit;
    logic          full;
    logic          pop;
    logic          push_ok;

    // Edge detect and frame check; the stop bit is the live sample, bits 0..9 sit in shift_q.
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        fall       = clk_sync_q[2] & ~clk_sync_q[1];
        bit_in     = dat_sync_q[1];
        frame_done = fall && (bit_cnt_q == 4'd10);
        frame_byte = shift_q[8:1];
        frame_good = frame_done && !shift_q[0] && (^shift_q[9:1]) && bit_in;
        tmo_hit    = (bit_cnt_q != 4'd0) && (tmo_q == TW'(TIMEOUT - 1));
    end

    // Bit counter, shift register and inter-edge timeout.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        if (fall) begin
            bit_cnt_d = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
            if (!frame_done) begin
                shift_d = {bit_in, shift_q[9:1]};
            end
        end else if (tmo_hit) begin
            // Stalled partial frame: drop it quietly.
            bit_cnt_d = 4'd0;
        end
        if (bit_cnt_q == 4'd0 || fall || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        frame_err_d = frame_done && !frame_good;
    end

    // FIFO: a pop frees a slot for a same-cycle push when full.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop        = bus.rd_en && (count_q != '0);
        push_ok    = frame_good && (!full || pop);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (frame_good && full && !pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = frame_byte;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Make/break tracking; E0 prefixes are transparent, F0 arms a release.
    always_comb begin
        cur_code_d = cur_code_q;
        key_down_d = key_down_q;
        key_cnt_d  = key_cnt_q;
        brk_d      = brk_q;
        if (frame_good && frame_byte != 8'hE0) begin
            if (frame_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (frame_byte == cur_code_q) begin
                    key_down_d = 1'b0;
                end
            end else if (!key_down_q || frame_byte != cur_code_q) begin
                cur_code_d = frame_byte;
                key_down_d = 1'b1;
                key_cnt_d  = key_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cur_code_q  <= '0;
            key_down_q  <= 1'b0;
            key_cnt_q   <= '0;
            brk_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            cur_code_q  <= cur_code_d;
            key_down_q  <= key_down_d;
            key_cnt_q   <= key_cnt_d;
            brk_q       <= brk_d;
        end
    end

    assign bus.rd_data   = mem_q[rd_ptr_q];
    assign bus.rd_valid  = (count_q != '0);
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
    assign bus.cur_code  = cur_code_q;
    assign bus.key_down  = key_down_q;
    assign bus.key_cnt   = key_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: drives PS/2 frames and checks against a queue/keystate model.
module tb_ps2_kbd_rx;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 2000;
    localparam int          H       = 3;    // PS/2 half period in system clocks

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;     // cycles seen with frame_err high
    int m_errs = 0;         // rejected frames expected by the model

    always @(negedge clk) if (bus.frame_err === 1'b1) err_cycles++;

    // Reference model
    logic [7:0] mq[$];
    bit         m_ovf;
    logic [7:0] m_cur;
    bit         m_down;
    logic [7:0] m_cnt;
    bit         m_brk;
    bit         hold;       // rd_en held high: FIFO drains after every push
    bit         pre_valid;  // rd_valid one cycle before the push edge

    function automatic void mdl_reset();
        mq.delete();
        m_ovf = 0; m_cur = 8'h00; m_down = 0; m_cnt = 8'h00; m_brk = 0;
    endfunction

    function automatic void mdl_keys(input logic [7:0] b);
        if (b == 8'hE0) return;
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            m_brk = 0;
            if (b == m_cur) m_down = 0;
        end else if (!m_down || b != m_cur) begin
            m_cur = b; m_down = 1; m_cnt = m_cnt + 8'd1;
        end
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive nbits of a frame; optionally hold rd_en on the cycle the last fall is acted on.
    task automatic send_frame(input logic [10:0] bits, input int nbits, input bit pop_last);
        bit good;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            @(negedge clk);
            @(negedge clk);
            pre_valid = bus.rd_valid;
            if (pop_last && i == nbits - 1) bus.rd_en = 1'b1;
            @(negedge clk);
            if (pop_last && i == nbits - 1) bus.rd_en = 1'b0;
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            good = (bits[0] == 1'b0) && (^bits[9:1] == 1'b1) && (bits[10] == 1'b1);
            if (pop_last && mq.size() > 0) void'(mq.pop_front());
            if (good) begin
                if (mq.size() < DEPTH) mq.push_back(bits[8:1]);
                else m_ovf = 1;
                mdl_keys(bits[8:1]);
            end else begin
                m_errs++;
            end
            if (hold) mq.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_last);
        send_frame(frame_bits(b, 1'b0), 11, pop_last);
    endtask

    task automatic pop_byte(output logic [7:0] got);
        got = bus.rd_data;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        mdl_reset();
        idle(4);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({bus.rd_valid, bus.overflow, bus.frame_err, bus.key_down} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.rd_valid, bus.overflow, bus.frame_err, bus.key_down});
        end
        checks++;
        if ({bus.cur_code, bus.key_cnt, bus.rd_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_bytes: got %h want 000000",
                     {bus.cur_code, bus.key_cnt, bus.rd_data});
        end
    endtask

    task automatic test_first_frame();
        send_byte(8'h1C, 1'b0);
        checks++;
        if (pre_valid !== 1'b0 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_timing: got before=%b after=%b want 0 then 1",
                     pre_valid, bus.rd_valid);
        end
        checks++;
        if (bus.rd_data !== 8'h1C) begin
            errors++; $display("FAIL first_rd_data: got %h want 1c", bus.rd_data);
        end
        checks++;
        if ({bus.cur_code, bus.key_down, bus.key_cnt} !== {m_cur, m_down, m_cnt}) begin
            errors++;
            $display("FAIL first_keystate: got %h/%b/%0d want %h/%b/%0d",
                     bus.cur_code, bus.key_down, bus.key_cnt, m_cur, m_down, m_cnt);
        end
        idle(2);
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        logic [7:0] got, exp;
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i], 1'b0);
            idle(2);
        end
        checks++;
        if (bus.key_cnt !== m_cnt || bus.key_down !== m_down) begin
            errors++;
            $display("FAIL typematic_keys: got cnt=%0d down=%b want cnt=%0d down=%b",
                     bus.key_cnt, bus.key_down, m_cnt, m_down);
        end
        checks++;
        if (mq.size() != 6 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL typematic_depth: got valid=%b model=%0d want 1/6",
                     bus.rd_valid, mq.size());
        end
        while (mq.size() > 0) begin
            exp = mq.pop_front();
            pop_byte(got);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL typematic_fifo: got %h want %h", got, exp);
            end
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL typematic_empty: got %b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_parity_err();
        logic [7:0] got, exp;
        int e0;
        send_byte(8'h2B, 1'b0);
        idle(2);
        e0 = err_cycles;
        send_frame(frame_bits(8'h44, 1'b1), 11, 1'b0);
        idle(4);
        checks++;
        if (err_cycles - e0 != 1) begin
            errors++;
            $display("FAIL parity_err_pulse: got %0d cycles want 1", err_cycles - e0);
        end
        checks++;
        if (bus.cur_code !== m_cur) begin
            errors++; $display("FAIL parity_cur: got %h want %h", bus.cur_code, m_cur);
        end
        send_byte(8'h32, 1'b0);
        idle(2);
        checks++;
        if (bus.cur_code !== 8'h32 || bus.cur_code !== m_cur) begin
            errors++; $display("FAIL after_err_cur: got %h want 32", bus.cur_code);
        end
        while (mq.size() > 0) begin
            exp = mq.pop_front();
            pop_byte(got);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL parity_fifo: got %h want %h", got, exp);
            end
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL parity_empty: got %b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_timeout();
        int e0;
        logic [7:0] got;
        send_frame(frame_bits(8'h55, 1'b0), 4, 1'b0);
        idle(TIMEOUT + 5);
        e0 = err_cycles;
        send_byte(8'h24, 1'b0);
        idle(3);
        checks++;
        if (err_cycles != e0) begin
            errors++; $display("FAIL timeout_err: got %0d pulses want 0", err_cycles - e0);
        end
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h24 || bus.cur_code !== m_cur) begin
            errors++;
            $display("FAIL timeout_rx: got valid=%b data=%h cur=%h want 1/24/%h",
                     bus.rd_valid, bus.rd_data, bus.cur_code, m_cur);
        end
        pop_byte(got);
        void'(mq.pop_front());
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            idle(2);
            if (i == 7) begin
                checks++;
                if (bus.overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_at_full: got %b want 0", bus.overflow);
                end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || !m_ovf) begin
            errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow);
        end
        send_byte(8'h6B, 1'b1);
        idle(2);
        checks++;
        if (mq.size() != DEPTH || bus.rd_data !== mq[0]) begin
            errors++;
            $display("FAIL full_push_pop_head: got %h want %h", bus.rd_data, mq[0]);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp = mq.pop_front();
            pop_byte(got);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL ovf_fifo[%0d]: got %h want %h", i, got, exp);
            end
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained: got valid=%b ovf=%b want 0/1",
                     bus.rd_valid, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h3A, 1'b0);
        idle(2);
        send_byte(8'h4B, 1'b1);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h4B || mq.size() != 1) begin
            errors++;
            $display("FAIL count1_push_pop: got valid=%b data=%h want 1/4b",
                     bus.rd_valid, bus.rd_data);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [10:0] bits;
        logic [7:0]  b, got, exp, last;
        bit          pl;
        last = 8'h1C;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2, 3:    b = last;
                default: b = 8'($urandom_range(0, 255));
            endcase
            last = b;
            bits = frame_bits(b, 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bits[9]  = ~bits[9];
                    1:       bits[0]  = 1'b1;
                    default: bits[10] = 1'b0;
                endcase
            end
            pl = ($urandom_range(0, 3) == 0);
            send_frame(bits, 11, pl);
            idle($urandom_range(2, 8));
            checks++;
            if ({bus.cur_code, bus.key_down, bus.key_cnt} !== {m_cur, m_down, m_cnt}) begin
                errors++;
                $display("FAIL rnd_keys[%0d]: got %h/%b/%0d want %h/%b/%0d", n,
                         bus.cur_code, bus.key_down, bus.key_cnt, m_cur, m_down, m_cnt);
            end
            checks++;
            if (bus.rd_valid !== (mq.size() > 0) || (mq.size() > 0 && bus.rd_data !== mq[0])) begin
                errors++;
                $display("FAIL rnd_fifo[%0d]: got valid=%b data=%h want size=%0d", n,
                         bus.rd_valid, bus.rd_data, mq.size());
            end
            checks++;
            if (err_cycles != m_errs || bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_err[%0d]: got err=%0d ovf=%b want %0d/%b", n,
                         err_cycles, bus.overflow, m_errs, m_ovf);
            end
            while (mq.size() > 5) begin
                exp = mq.pop_front();
                pop_byte(got);
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL rnd_pop: got %h want %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        reset_dut();
        hold = 1;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            code = (i % 2 == 1) ? 8'h1D : 8'h15;
            send_byte(code, 1'b0);
            idle(2);
            send_byte(8'hF0, 1'b0);
            idle(2);
            send_byte(code, 1'b0);
            idle(2);
            if (i == 254) begin
                checks++;
                if (bus.key_cnt !== m_cnt) begin
                    errors++; $display("FAIL cnt_255: got %0d want %0d", bus.key_cnt, m_cnt);
                end
            end
        end
        bus.rd_en = 1'b0;
        hold = 0;
        checks++;
        if (bus.key_cnt !== m_cnt || bus.key_down !== m_down || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt=%0d down=%b valid=%b want %0d/%b/0",
                     bus.key_cnt, bus.key_down, bus.rd_valid, m_cnt, m_down);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        send_byte(8'h4D, 1'b0);
        idle(2);
        send_frame(frame_bits(8'h66, 1'b0), 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rd_valid, bus.overflow, bus.frame_err, bus.key_down, bus.cur_code,
             bus.key_cnt, bus.rd_data} !== 28'h0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b o=%b e=%b d=%b cur=%h cnt=%h data=%h want 0",
                     bus.rd_valid, bus.overflow, bus.frame_err, bus.key_down,
                     bus.cur_code, bus.key_cnt, bus.rd_data);
        end
        rst = 1'b0;
        mdl_reset();
        idle(3);
        e0 = err_cycles;
        send_byte(8'h5A, 1'b0);
        idle(2);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A || bus.cur_code !== m_cur ||
            bus.key_cnt !== m_cnt || err_cycles != e0) begin
            errors++;
            $display("FAIL post_reset_rx: got v=%b data=%h cur=%h cnt=%0d want 1/5a/%h/%0d",
                     bus.rd_valid, bus.rd_data, bus.cur_code, bus.key_cnt, m_cur, m_cnt);
        end
    endtask

    initial begin
        bus.rd_en = 1'b0;
        hold = 0;
        mdl_reset();
        test_reset();
        test_first_frame();
        test_typematic();
        test_parity_err();
        test_timeout();
        test_overflow();
        reset_dut();
        m_errs = err_cycles;
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
